// File: rtl/fetch_unit.sv
// Instruction fetch stage: samples the PC on start, reads instruction memory
// through a variable-latency ready handshake and holds the word for decode.
module fetch_unit #(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [31:0]       pc_q,
  input  logic              redirect,
  output logic              pc_inc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_rdy,
  input  logic [31:0]       mem_data,
  output logic [31:0]       ir_q,
  output logic              ir_valid,
  input  logic              ir_ack,
  output logic              busy,
  output logic              fault
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FULL
  } state_t;

  localparam logic [3:0] LAST_WAIT = 4'(TIMEOUT - 1);

  state_t            state, state_d;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0]       ir_d;
  logic              fault_d;
  logic [3:0]        cnt, cnt_d;
  logic              pc_in_range;
  logic              start_ok;

  // Upper PC bits must be zero for the address to lie inside the memory.
  assign pc_in_range = ((pc_q >> ADDR_W) == '0);
  assign start_ok    = start && !fault && !redirect;

  always_comb begin
    state_d  = state;
    addr_d   = mem_addr;
    ir_d     = ir_q;
    fault_d  = fault;
    cnt_d    = cnt;
    pc_inc   = 1'b0;
    mem_rd   = 1'b0;
    ir_valid = 1'b0;
    busy     = (state != S_IDLE);

    unique case (state)
      S_IDLE: begin
        if (start_ok) begin
          if (!pc_in_range) begin
            fault_d = 1'b1;
          end else begin
            addr_d  = pc_q[ADDR_W-1:0];
            state_d = S_REQ;
          end
        end
      end

      S_REQ: begin
        mem_rd = 1'b1;
        pc_inc = 1'b1;
        cnt_d  = '0;
        state_d = redirect ? S_IDLE : S_WAIT;
      end

      S_WAIT: begin
        mem_rd = 1'b1;
        // An abort wins over both returning data and the timeout.
        if (redirect) begin
          state_d = S_IDLE;
        end else if (mem_rdy) begin
          ir_d    = mem_data;
          state_d = S_FULL;
        end else if (cnt == LAST_WAIT) begin
          fault_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt + 4'd1;
        end
      end

      S_FULL: begin
        ir_valid = 1'b1;
        if (redirect) begin
          state_d = S_IDLE;
        end else if (ir_ack) begin
          state_d = S_IDLE;
          if (start_ok) begin
            if (!pc_in_range) begin
              fault_d = 1'b1;
            end else begin
              addr_d  = pc_q[ADDR_W-1:0];
              state_d = S_REQ;
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= S_IDLE;
      mem_addr <= '0;
      ir_q     <= '0;
      fault    <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_d;
      mem_addr <= addr_d;
      ir_q     <= ir_d;
      fault    <= fault_d;
      cnt      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: per-cycle vector table plus hand sequences for the
// timeout and minimum-latency cases; captured words go through a scoreboard.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        clr, start, redirect, mem_rdy, ir_ack;
  logic [31:0] pc_q, mem_data;
  logic        pc_inc, mem_rd, ir_valid, busy, fault;
  logic [8:0]  mem_addr;
  logic [31:0] ir_q;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic        prev_valid = 1'b0;
  logic [31:0] sb_q[$];

  fetch_unit #(.ADDR_W(9), .TIMEOUT(15)) dut (
    .clk(clk), .clr(clr), .start(start), .pc_q(pc_q), .redirect(redirect),
    .pc_inc(pc_inc), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdy(mem_rdy),
    .mem_data(mem_data), .ir_q(ir_q), .ir_valid(ir_valid), .ir_ack(ir_ack),
    .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        clr, start;
    logic [31:0] pc;
    logic        redir, rdy;
    logic [31:0] data;
    logic        ack, push;
    logic        e_inc, e_rd;
    logic [8:0]  e_addr;
    logic [31:0] e_ir;
    logic        e_valid, e_busy, e_fault;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic c, logic s, logic [31:0] pc, logic r, logic rdy,
                             logic [31:0] d, logic a, logic p, logic ei, logic er,
                             logic [8:0] ea, logic [31:0] eir, logic ev, logic eb,
                             logic ef);
    vec_t x;
    x.clr = c; x.start = s; x.pc = pc; x.redir = r; x.rdy = rdy; x.data = d;
    x.ack = a; x.push = p; x.e_inc = ei; x.e_rd = er; x.e_addr = ea; x.e_ir = eir;
    x.e_valid = ev; x.e_busy = eb; x.e_fault = ef;
    return x;
  endfunction

  task automatic chk(input string nm, input int tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d: got %h expected %h", nm, tag, act, exp);
    end
  endtask

  task automatic idle_inputs();
    clr = 0; start = 0; pc_q = '0; redirect = 0; mem_rdy = 0; mem_data = '0; ir_ack = 0;
  endtask

  // One clock; sample just after the edge and retire a scoreboard entry when
  // ir_valid rises.
  task automatic step();
    logic [31:0] exp_w;
    @(posedge clk);
    #1;
    if (ir_valid && !prev_valid) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected", 0, ir_q, 32'hxxxx_xxxx);
      end else begin
        exp_w = sb_q.pop_front();
        chk("sb_ir_q", 0, ir_q, exp_w);
      end
    end
    prev_valid = ir_valid;
  endtask

  initial begin
    idle_inputs();
    clr = 1;
    //          clr st pc        rd rdy data          ack psh inc rdq addr    ir            v  b  f
    vecs.push_back(v(1, 0, 32'h0,   0, 0, 32'h0,        0, 0,  0, 0, 9'h000, 32'h0,        0, 0, 0));
    // basic fetch
    vecs.push_back(v(0, 1, 32'h5,   0, 0, 32'h0,        0, 0,  1, 1, 9'h005, 32'h0,        0, 1, 0));
    vecs.push_back(v(0, 0, 32'h0,   0, 0, 32'h0,        0, 0,  0, 1, 9'h005, 32'h0,        0, 1, 0));
    vecs.push_back(v(0, 0, 32'h0,   0, 0, 32'h0,        0, 0,  0, 1, 9'h005, 32'h0,        0, 1, 0));
    vecs.push_back(v(0, 0, 32'h0,   0, 1, 32'hA1B2C3D4, 0, 1,  0, 0, 9'h005, 32'hA1B2C3D4, 1, 1, 0));
    vecs.push_back(v(0, 0, 32'h0,   0, 0, 32'h0,        0, 0,  0, 0, 9'h005, 32'hA1B2C3D4, 1, 1, 0));
    vecs.push_back(v(0, 1, 32'h9,   0, 0, 32'h0,        0, 0,  0, 0, 9'h005, 32'hA1B2C3D4, 1, 1, 0));
    // back-to-back
    vecs.push_back(v(0, 1, 32'h6,   0, 0, 32'h0,        1, 0,  1, 1, 9'h006, 32'hA1B2C3D4, 0, 1, 0));
    vecs.push_back(v(0, 0, 32'h0,   0, 0, 32'h0,        0, 0,  0, 1, 9'h006, 32'hA1B2C3D4, 0, 1, 0));
    vecs.push_back(v(0, 0, 32'h0,   0, 1, 32'h11223344, 0, 1,  0, 0, 9'h006, 32'h11223344, 1, 1, 0));
    vecs.push_back(v(0, 0, 32'h0,   0, 0, 32'h0,        1, 0,  0, 0, 9'h006, 32'h11223344, 0, 0, 0));
    // redirect colliding with mem_rdy in WAIT
    vecs.push_back(v(0, 1, 32'h1F,  0, 0, 32'h0,        0, 0,  1, 1, 9'h01F, 32'h11223344, 0, 1, 0));
    vecs.push_back(v(0, 0, 32'h0,   0, 0, 32'h0,        0, 0,  0, 1, 9'h01F, 32'h11223344, 0, 1, 0));
    vecs.push_back(v(0, 0, 32'h0,   1, 1, 32'hDEADBEEF, 0, 0,  0, 0, 9'h01F, 32'h11223344, 0, 0, 0));
    // redirect in IDLE blocks start
    vecs.push_back(v(0, 1, 32'h20,  1, 0, 32'h0,        0, 0,  0, 0, 9'h01F, 32'h11223344, 0, 0, 0));
    // redirect in REQ
    vecs.push_back(v(0, 1, 32'h30,  0, 0, 32'h0,        0, 0,  1, 1, 9'h030, 32'h11223344, 0, 1, 0));
    vecs.push_back(v(0, 0, 32'h0,   1, 0, 32'h0,        0, 0,  0, 0, 9'h030, 32'h11223344, 0, 0, 0));
    // rdy during REQ ignored, then redirect in FULL
    vecs.push_back(v(0, 1, 32'h40,  0, 0, 32'h0,        0, 0,  1, 1, 9'h040, 32'h11223344, 0, 1, 0));
    vecs.push_back(v(0, 0, 32'h0,   0, 1, 32'h55AA55AA, 0, 0,  0, 1, 9'h040, 32'h11223344, 0, 1, 0));
    vecs.push_back(v(0, 0, 32'h0,   0, 1, 32'h0BADF00D, 0, 1,  0, 0, 9'h040, 32'h0BADF00D, 1, 1, 0));
    vecs.push_back(v(0, 1, 32'h41,  1, 0, 32'h0,        1, 0,  0, 0, 9'h040, 32'h0BADF00D, 0, 0, 0));
    // range fault, sticky until clr
    vecs.push_back(v(0, 1, 32'h200, 0, 0, 32'h0,        0, 0,  0, 0, 9'h040, 32'h0BADF00D, 0, 0, 1));
    vecs.push_back(v(0, 1, 32'h1,   0, 0, 32'h0,        0, 0,  0, 0, 9'h040, 32'h0BADF00D, 0, 0, 1));
    vecs.push_back(v(0, 1, 32'h1,   0, 0, 32'h0,        0, 0,  0, 0, 9'h040, 32'h0BADF00D, 0, 0, 1));
    vecs.push_back(v(1, 0, 32'h0,   0, 0, 32'h0,        0, 0,  0, 0, 9'h000, 32'h0,        0, 0, 0));
    // clr mid-fetch, late rdy ignored
    vecs.push_back(v(0, 1, 32'h1FF, 0, 0, 32'h0,        0, 0,  1, 1, 9'h1FF, 32'h0,        0, 1, 0));
    vecs.push_back(v(0, 0, 32'h0,   0, 0, 32'h0,        0, 0,  0, 1, 9'h1FF, 32'h0,        0, 1, 0));
    vecs.push_back(v(1, 0, 32'h0,   0, 0, 32'h0,        0, 0,  0, 0, 9'h000, 32'h0,        0, 0, 0));
    vecs.push_back(v(0, 0, 32'h0,   0, 1, 32'hCAFEBABE, 0, 0,  0, 0, 9'h000, 32'h0,        0, 0, 0));
    // back-to-back start out of range faults while completing the handshake
    vecs.push_back(v(0, 1, 32'h2,   0, 0, 32'h0,        0, 0,  1, 1, 9'h002, 32'h0,        0, 1, 0));
    vecs.push_back(v(0, 0, 32'h0,   0, 0, 32'h0,        0, 0,  0, 1, 9'h002, 32'h0,        0, 1, 0));
    vecs.push_back(v(0, 0, 32'h0,   0, 1, 32'h12345678, 0, 1,  0, 0, 9'h002, 32'h12345678, 1, 1, 0));
    vecs.push_back(v(0, 1, 32'h400, 0, 0, 32'h0,        1, 0,  0, 0, 9'h002, 32'h12345678, 0, 0, 1));
    vecs.push_back(v(1, 0, 32'h0,   0, 0, 32'h0,        0, 0,  0, 0, 9'h000, 32'h0,        0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      clr = vecs[i].clr; start = vecs[i].start; pc_q = vecs[i].pc;
      redirect = vecs[i].redir; mem_rdy = vecs[i].rdy; mem_data = vecs[i].data;
      ir_ack = vecs[i].ack;
      if (vecs[i].push) sb_q.push_back(vecs[i].data);
      step();
      chk("pc_inc",   i, 32'(pc_inc),   32'(vecs[i].e_inc));
      chk("mem_rd",   i, 32'(mem_rd),   32'(vecs[i].e_rd));
      chk("mem_addr", i, 32'(mem_addr), 32'(vecs[i].e_addr));
      chk("ir_q",     i, ir_q,          vecs[i].e_ir);
      chk("ir_valid", i, 32'(ir_valid), 32'(vecs[i].e_valid));
      chk("busy",     i, 32'(busy),     32'(vecs[i].e_busy));
      chk("fault",    i, 32'(fault),    32'(vecs[i].e_fault));
    end

    // Timeout: start in cycle 0, WAIT through cycle 16, fault at cycle 17.
    idle_inputs();
    start = 1; pc_q = 32'h7;
    step();
    start = 0;
    chk("to_rd_c1", 1, 32'(mem_rd), 32'd1);
    chk("to_inc_c1", 1, 32'(pc_inc), 32'd1);
    for (int c = 2; c <= 16; c++) begin
      step();
      chk("to_rd", c, 32'(mem_rd), 32'd1);
      chk("to_inc", c, 32'(pc_inc), 32'd0);
      chk("to_fault", c, 32'(fault), 32'd0);
      chk("to_addr", c, 32'(mem_addr), 32'h7);
    end
    step();
    chk("to_fault_c17", 17, 32'(fault), 32'd1);
    chk("to_busy_c17", 17, 32'(busy), 32'd0);
    chk("to_rd_c17", 17, 32'(mem_rd), 32'd0);
    start = 1; pc_q = 32'h3;
    step();
    chk("to_ignored_start", 18, 32'(busy), 32'd0);
    start = 0; clr = 1;
    step();
    clr = 0;
    chk("to_clr_fault", 19, 32'(fault), 32'd0);

    // Minimum latency: rdy in cycle 2 gives ir_valid in cycle 3.
    start = 1; pc_q = 32'h8;
    step();
    start = 0;
    step();
    mem_rdy = 1; mem_data = 32'h0000_0077;
    sb_q.push_back(32'h0000_0077);
    step();
    mem_rdy = 0;
    chk("lat_valid_c3", 3, 32'(ir_valid), 32'd1);
    ir_ack = 1;
    step();
    ir_ack = 0;
    chk("lat_ack_idle", 4, 32'(busy), 32'd0);

    chk("sb_drained", 0, 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly downstream of the PC register. On a `start` request from the control unit it samples the PC value and issues a read to instruction memory. It then waits on a variable-latency ready handshake and captures the returned word into an instruction register. The word is held there with a valid/ack handshake for the decode stage. The block also drives the PC register's increment strobe and aborts in-flight fetches when the PC is redirected by a branch.

## Interface
Parameters:
- `ADDR_W`, 9: memory word-address width (512-word memory).
- `TIMEOUT`, 15: maximum number of WAIT cycles before a fetch is declared failed; range 1–15.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `clr` in 1: reset, synchronous, active-high.
- `start` in 1: control unit requests a fetch (T0).
- `pc_q` in 32: current PC register value.
- `redirect` in 1: the PC is being written this cycle (branch/jump).
- `pc_inc` out 1: one-cycle increment strobe to the PC register.
- `mem_addr` out ADDR_W: registered read address.
- `mem_rd` out 1: read request.
- `mem_rdy` in 1: memory data valid.
- `mem_data` in 32: memory read data.
- `ir_q` out 32: captured instruction.
- `ir_valid` out 1: `ir_q` holds an unconsumed instruction.
- `ir_ack` in 1: decode consumes `ir_q`.
- `busy` out 1: state is not IDLE.
- `fault` out 1: sticky error flag (address out of range or timeout).

## Operation
- States are IDLE, REQ, WAIT and FULL.
- **IDLE:**
  - If `start` and `!fault` and `!redirect`:
    - If `pc_q[31:ADDR_W] != 0`, set `fault`=1 and stay in IDLE.
    - Otherwise latch `mem_addr <= pc_q[ADDR_W-1:0]` and go to REQ.
- **REQ:** `mem_rd`=1 and `pc_inc`=1 for exactly this one cycle. `mem_rdy` is ignored. Clear the wait counter and go to WAIT.
- **WAIT:**
  - `mem_rd`=1.
  - On `mem_rdy`: `ir_q <= mem_data`, go to FULL.
  - Otherwise the wait counter (4 bits) increments. If the counter equals `TIMEOUT-1` with no `mem_rdy`, set `fault`=1 and go to IDLE; `ir_q` is unchanged.
- **FULL:**
  - `ir_valid`=1.
  - On `ir_ack`, go to IDLE.
  - On `ir_ack && start` in the same cycle (back-to-back), apply the IDLE start rules to `pc_q` in that cycle and go directly to REQ (or to IDLE with `fault` set).
  - `start` without `ir_ack` is ignored.
- **redirect:**
  - In REQ or WAIT: abort, go to IDLE, and discard any `mem_rdy`/`mem_data` seen that cycle. `redirect` beats `mem_rdy`.
  - In FULL: drop `ir_valid` and go to IDLE; `ir_q` keeps its value but is stale.
  - In IDLE: `start` is ignored that cycle.
- `fault` stays set until `clr`; while it is set, `start` is ignored. An in-progress FULL handshake still completes.
- `mem_addr` is held constant from REQ until the block leaves WAIT, and keeps its last value in IDLE and FULL.
- Output decode: `busy` = (state != IDLE); `ir_valid` = (state == FULL).
- **clr:** takes priority over every other input. Next state is IDLE, and all outputs are 0: `mem_addr`, `ir_q`, `ir_valid`, `mem_rd`, `pc_inc`, `busy`, `fault`. The wait counter is also cleared.

## Timing
- Cycle 0: IDLE, `start`=1.
- Cycle 1: REQ; `mem_rd`=1, `mem_addr` valid, `pc_inc`=1.
- Cycle 2 onward: WAIT.
- `mem_rdy` in cycle k (k≥2) gives `ir_valid`=1 from cycle k+1. Minimum start→`ir_valid` latency is 3 cycles.
- `pc_inc` is a single-cycle pulse per accepted fetch, including fetches later aborted by `redirect` (the PC write overrides it).
- Timeout: with `TIMEOUT`=15 and `mem_rdy` never asserted, the WAIT cycles are 2..16 and `fault`=1 from cycle 17.
- Back-to-back: `ir_ack`+`start` in cycle n gives REQ in cycle n+1, with `ir_valid`=0 in cycle n+1.
- A `clr` asserted in any cycle yields the full reset state in the next cycle. A `mem_rdy` arriving after `clr` is ignored.

## Test plan
- **Basic fetch:** clr, then `pc_q`=0x5 and `start` at cycle 0; `mem_rdy`=1 with `mem_data`=0xA1B2C3D4 at cycle 3. Required: `mem_addr`=0x005, `pc_inc` only at cycle 1, `ir_q`=0xA1B2C3D4 and `ir_valid`=1 from cycle 4; `ir_ack` returns the block to IDLE.
- **Back-to-back:** while FULL, assert `ir_ack`+`start` with `pc_q`=0x6. Required: REQ the next cycle with `mem_addr`=0x006 and a single `pc_inc`.
- **Redirect with rdy collision:** in WAIT, `redirect`=1 and `mem_rdy`=1 (`mem_data`=0xDEADBEEF). Required: IDLE next cycle, `ir_q` unchanged, `ir_valid`=0.
- **Range fault:** `start` with `pc_q`=0x200. Required: `fault`=1, `mem_rd` never asserted, and a later `start` with `pc_q`=0x1 is ignored until `clr`.
- **Timeout:** `TIMEOUT`=15 and `mem_rdy` held low. Required: `mem_rd`=1 for cycles 1..16, `fault`=1 and IDLE at cycle 17.
- **Reset mid-fetch:** `clr` in WAIT, then `mem_rdy` one cycle later. Required: all outputs 0, state IDLE, and the late data is not captured.
